csr_access_controller: RTL

//  Sequences every CSR read-modify-write for the machine-mode CSR file: arbitrates between the core

---
 rtl/csr_access_controller_if.sv | 55 +++++
 rtl/csr_access_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/csr_access_controller_if.sv
// Request/response/CSR-bank signal bundle for csr_access_controller.
// slave modport: controller side. master modport: requesters, response consumer and CSR bank.
interface csr_access_controller_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              core_req_valid_in;
  logic              core_req_ready_out;
  logic [ADDR_W-1:0] core_req_addr_in;
  logic [1:0]        core_req_op_in;
  logic [DATA_W-1:0] core_req_wdata_in;

  logic              dbg_req_valid_in;
  logic              dbg_req_ready_out;
  logic [ADDR_W-1:0] dbg_req_addr_in;
  logic [1:0]        dbg_req_op_in;
  logic [DATA_W-1:0] dbg_req_wdata_in;

  logic              rsp_valid_out;
  logic              rsp_ready_in;
  logic              rsp_id_out;
  logic [DATA_W-1:0] rsp_rdata_out;
  logic              rsp_err_out;

  logic [ADDR_W-1:0] csr_addr_out;
  logic [DATA_W-1:0] csr_rdata_in;
  logic              csr_wr_en_out;
  logic [DATA_W-1:0] csr_wdata_out;

  logic              busy_out;

  modport slave (
    input  core_req_valid_in, core_req_addr_in, core_req_op_in, core_req_wdata_in,
    output core_req_ready_out,
    input  dbg_req_valid_in, dbg_req_addr_in, dbg_req_op_in, dbg_req_wdata_in,
    output dbg_req_ready_out,
    output rsp_valid_out, rsp_id_out, rsp_rdata_out, rsp_err_out,
    input  rsp_ready_in,
    output csr_addr_out, csr_wr_en_out, csr_wdata_out,
    input  csr_rdata_in,
    output busy_out
  );

  modport master (
    output core_req_valid_in, core_req_addr_in, core_req_op_in, core_req_wdata_in,
    input  core_req_ready_out,
    output dbg_req_valid_in, dbg_req_addr_in, dbg_req_op_in, dbg_req_wdata_in,
    input  dbg_req_ready_out,
    input  rsp_valid_out, rsp_id_out, rsp_rdata_out, rsp_err_out,
    output rsp_ready_in,
    input  csr_addr_out, csr_wr_en_out, csr_wdata_out,
    output csr_rdata_in,
    input  busy_out
  );
endinterface

// File: rtl/csr_access_controller.sv
// CSR read-modify-write sequencer: round-robin arbitration between core and debug
// requesters, fixed IDLE -> READ -> WRITE -> RESP sequence, one write strobe per op.
// Optional macro CSR_ACCESS_CHECK_EN enables implemented-address and read-only checks.
module csr_access_controller #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic                    clk_in,
  input logic                    rst_in,
  csr_access_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_RW, OP_RS, OP_RC} op_t;

  state_t            state, state_nxt;
  logic              core_grant, dbg_grant;
  logic              last_dbg;
  logic [ADDR_W-1:0] addr_q;
  op_t               op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              id_q;
  logic [DATA_W-1:0] old_q;
  logic              write_attempt;
  logic [DATA_W-1:0] new_value;
  logic [DATA_W-1:0] read_value;
  logic              access_err;
  logic              err_q;

`ifdef CSR_ACCESS_CHECK_EN
  function automatic logic is_implemented(input logic [ADDR_W-1:0] a);
    logic [11:0] a12;
    a12 = a[11:0];
    return a12 inside {[12'hC00:12'hC02], [12'hC80:12'hC82], 12'h300, 12'h301,
                       12'h304, 12'h305, 12'h320, [12'h340:12'h344],
                       12'hB00, 12'hB02, 12'hB80, 12'hB82};
  endfunction
`endif

  // Round-robin grant: contested cycles go to whichever requester was not granted last.
  always_comb begin
    core_grant = 1'b0;
    dbg_grant  = 1'b0;
    if (state == IDLE) begin
      core_grant = bus.core_req_valid_in && (!bus.dbg_req_valid_in || last_dbg);
      dbg_grant  = bus.dbg_req_valid_in && (!bus.core_req_valid_in || !last_dbg);
    end
  end

  // Write intent and value merge from the latched op and captured old value.
  always_comb begin
    write_attempt = (op_q == OP_RW) ||
                    (((op_q == OP_RS) || (op_q == OP_RC)) && (wdata_q != '0));
    new_value = old_q;
    case (op_q)
      OP_RW:   new_value = wdata_q;
      OP_RS:   new_value = old_q | wdata_q;
      OP_RC:   new_value = old_q & ~wdata_q;
      default: new_value = old_q;
    endcase
  end

  // Access check evaluated during READ; unimplemented addresses read back as zero.
  always_comb begin
    read_value = bus.csr_rdata_in;
    access_err = 1'b0;
`ifdef CSR_ACCESS_CHECK_EN
    if (!is_implemented(addr_q)) begin
      read_value = '0;
      access_err = 1'b1;
    end else if (write_attempt && (addr_q[11:10] == 2'b11)) begin
      access_err = 1'b1;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed one-cycle READ and WRITE, RESP waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_grant || dbg_grant) state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = RESP;
      RESP:    if (bus.rsp_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, arbitration history and old-value capture.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_dbg <= 1'b1;
      addr_q   <= '0;
      op_q     <= OP_READ;
      wdata_q  <= '0;
      id_q     <= 1'b0;
      old_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (core_grant) begin
        last_dbg <= 1'b0;
        addr_q   <= bus.core_req_addr_in;
        op_q     <= op_t'(bus.core_req_op_in);
        wdata_q  <= bus.core_req_wdata_in;
        id_q     <= 1'b0;
      end else if (dbg_grant) begin
        last_dbg <= 1'b1;
        addr_q   <= bus.dbg_req_addr_in;
        op_q     <= op_t'(bus.dbg_req_op_in);
        wdata_q  <= bus.dbg_req_wdata_in;
        id_q     <= 1'b1;
      end
      if (state == READ) begin
        old_q <= read_value;
        err_q <= access_err;
      end
    end
  end

  assign bus.core_req_ready_out = core_grant;
  assign bus.dbg_req_ready_out  = dbg_grant;
  assign bus.csr_addr_out       = addr_q;
  assign bus.csr_wdata_out      = new_value;
  assign bus.csr_wr_en_out      = (state == WRITE) && write_attempt && !err_q;
  assign bus.rsp_valid_out      = (state == RESP);
  assign bus.rsp_id_out         = id_q;
  assign bus.rsp_rdata_out      = old_q;
  assign bus.busy_out           = (state != IDLE);
`ifdef CSR_ACCESS_CHECK_EN
  assign bus.rsp_err_out        = err_q;
`else
  assign bus.rsp_err_out        = 1'b0;
`endif

endmodule
